// File: rtl/text_term_writer.sv
// Byte-stream terminal front end: decodes printable/control bytes, keeps the cursor
// and emits {attr,char} cell writes into the COLS x ROWS text VRAM.
module text_term_writer #(
  parameter int          COLS       = 90,
  parameter int          ROWS       = 30,
  parameter logic [7:0]  BLANK_CHAR = 8'h20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  in_char,
  input  logic [7:0]  in_attr,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] vram_a,
  output logic [31:0] vram_d,
  output logic        vram_we,
  output logic [6:0]  cur_col,
  output logic [4:0]  cur_row
);

  // state      | meaning
  // CLEAR_ALL  | blanking every cell, index = cnt
  // IDLE       | waiting for a byte, in_ready high
  // WRITE      | printable cell strobe on the bus, cursor advances on exit
  // CLEAR_ROW  | blanking the cursor row, index = row*COLS + cnt
  localparam logic [1:0] S_CLEAR_ALL = 2'd0;
  localparam logic [1:0] S_IDLE      = 2'd1;
  localparam logic [1:0] S_WRITE     = 2'd2;
  localparam logic [1:0] S_CLEAR_ROW = 2'd3;

  localparam logic [11:0] COLS_12   = 12'(COLS);
  localparam logic [11:0] LAST_CELL = 12'(COLS * ROWS - 1);
  localparam logic [11:0] LAST_COLK = 12'(COLS - 1);
  localparam logic [6:0]  LAST_COL  = 7'(COLS - 1);
  localparam logic [4:0]  LAST_ROW  = 5'(ROWS - 1);

  localparam logic [7:0] CH_BS = 8'h08;
  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_FF = 8'h0C;
  localparam logic [7:0] CH_CR = 8'h0D;

  logic [1:0]  state_q, state_d;
  logic [11:0] cnt_q, cnt_d;
  logic [6:0]  col_q, col_d;
  logic [4:0]  row_q, row_d;
  logic [7:0]  last_attr_q, last_attr_d;
  logic [31:0] vram_a_q, vram_a_d;
  logic [31:0] vram_d_q, vram_d_d;
  logic        vram_we_q, vram_we_d;

  logic        accept;
  logic [4:0]  next_row;
  logic [11:0] row_base;
  logic [11:0] cursor_idx;

  assign in_ready   = rst && (state_q == S_IDLE);
  assign accept     = in_valid && in_ready;
  assign next_row   = (row_q == LAST_ROW) ? 5'd0 : row_q + 5'd1;
  assign row_base   = 12'(row_q) * COLS_12;
  assign cursor_idx = row_base + 12'(col_q);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    col_d       = col_q;
    row_d       = row_q;
    last_attr_d = last_attr_q;
    vram_a_d    = vram_a_q;
    vram_d_d    = vram_d_q;
    vram_we_d   = 1'b0;

    case (state_q)
      S_CLEAR_ALL: begin
        vram_we_d = 1'b1;
        vram_a_d  = {18'b0, cnt_q, 2'b00};
        vram_d_d  = {16'b0, last_attr_q, BLANK_CHAR};
        if (cnt_q == LAST_CELL) begin
          cnt_d   = 12'd0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 12'd1;
        end
      end

      S_IDLE: begin
        if (accept) begin
          last_attr_d = in_attr;
          if (in_char >= 8'h20 && in_char <= 8'h7E) begin
            vram_we_d = 1'b1;
            vram_a_d  = {18'b0, cursor_idx, 2'b00};
            vram_d_d  = {16'b0, in_attr, in_char};
            state_d   = S_WRITE;
          end else begin
            case (in_char)
              CH_LF: begin
                col_d   = 7'd0;
                row_d   = next_row;
                cnt_d   = 12'd0;
                state_d = S_CLEAR_ROW;
              end
              CH_CR: col_d = 7'd0;
              CH_BS: if (col_q != 7'd0) col_d = col_q - 7'd1;
              CH_FF: begin
                col_d   = 7'd0;
                row_d   = 5'd0;
                cnt_d   = 12'd0;
                state_d = S_CLEAR_ALL;
              end
              default: ;
            endcase
          end
        end
      end

      S_WRITE: begin
        if (col_q < LAST_COL) begin
          col_d   = col_q + 7'd1;
          state_d = S_IDLE;
        end else begin
          col_d   = 7'd0;
          row_d   = next_row;
          cnt_d   = 12'd0;
          state_d = S_CLEAR_ROW;
        end
      end

      S_CLEAR_ROW: begin
        // row_q already points at the new row when this state is entered
        vram_we_d = 1'b1;
        vram_a_d  = {18'b0, row_base + cnt_q, 2'b00};
        vram_d_d  = {16'b0, last_attr_q, BLANK_CHAR};
        if (cnt_q == LAST_COLK) begin
          cnt_d   = 12'd0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 12'd1;
        end
      end

      default: state_d = S_CLEAR_ALL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_CLEAR_ALL;
      cnt_q       <= 12'd0;
      col_q       <= 7'd0;
      row_q       <= 5'd0;
      last_attr_q <= 8'h00;
      vram_a_q    <= 32'd0;
      vram_d_q    <= 32'd0;
      vram_we_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      col_q       <= col_d;
      row_q       <= row_d;
      last_attr_q <= last_attr_d;
      vram_a_q    <= vram_a_d;
      vram_d_q    <= vram_d_d;
      vram_we_q   <= vram_we_d;
    end
  end

  assign vram_a  = vram_a_q;
  assign vram_d  = vram_d_q;
  assign vram_we = vram_we_q;
  assign cur_col = col_q;
  assign cur_row = row_q;

endmodule

// File: tb/tb_text_term_writer.sv
// Directed bench for text_term_writer: full clears, printable writes, wrap,
// control codes, back-to-back bytes and reset during a clear.
module tb_text_term_writer;
  logic        clk;
  logic        rst;
  logic [7:0]  in_char;
  logic [7:0]  in_attr;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] vram_a;
  logic [31:0] vram_d;
  logic        vram_we;
  logic [6:0]  cur_col;
  logic [4:0]  cur_row;

  int checks;
  int failures;

  text_term_writer dut (
    .clk      (clk),
    .rst      (rst),
    .in_char  (in_char),
    .in_attr  (in_attr),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .vram_a   (vram_a),
    .vram_d   (vram_d),
    .vram_we  (vram_we),
    .cur_col  (cur_col),
    .cur_row  (cur_row)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic wait_ready();
    int n = 0;
    while (in_ready !== 1'b1 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (in_ready !== 1'b1) begin
      checks++; failures++;
      $display("FAIL ready_timeout in_ready=%b expected 1", in_ready);
    end
  endtask

  task automatic send_byte(input logic [7:0] c, input logic [7:0] a);
    wait_ready();
    in_char  = c;
    in_attr  = a;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Called on the negedge where rst has just been released.
  task automatic check_full_clear(input string nm);
    int low = 1;
    int writes = 0;
    int bad = 0;
    int n = 0;
    while (n < 3000) begin
      @(negedge clk);
      n++;
      if (vram_we === 1'b1) begin
        if (vram_a !== 32'(writes * 4) || vram_d !== 32'h0000_0020) bad++;
        writes++;
      end
      if (in_ready === 1'b1) break;
      low++;
    end
    checks++;
    if (low !== 2700) begin failures++; $display("FAIL %s_ready_low got=%0d exp=2700", nm, low); end
    checks++;
    if (writes !== 2700) begin failures++; $display("FAIL %s_writes got=%0d exp=2700", nm, writes); end
    checks++;
    if (bad !== 0) begin failures++; $display("FAIL %s_addr_data bad=%0d exp=0", nm, bad); end
    checks++;
    if (vram_a !== 32'h0000_2A2C) begin failures++; $display("FAIL %s_last_addr got=%h exp=00002a2c", nm, vram_a); end
    checks++;
    if (cur_col !== 7'd0 || cur_row !== 5'd0) begin
      failures++; $display("FAIL %s_cursor got=(%0d,%0d) exp=(0,0)", nm, cur_col, cur_row);
    end
    @(negedge clk);
    checks++;
    if (vram_we !== 1'b0 || in_ready !== 1'b1) begin
      failures++; $display("FAIL %s_after we=%b ready=%b exp we=0 ready=1", nm, vram_we, in_ready);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (in_ready !== 1'b0 || vram_we !== 1'b0) begin
      failures++; $display("FAIL reset_ctrl ready=%b we=%b exp 0 0", in_ready, vram_we);
    end
    checks++;
    if (vram_a !== 32'd0 || vram_d !== 32'd0) begin
      failures++; $display("FAIL reset_bus a=%h d=%h exp 0 0", vram_a, vram_d);
    end
    checks++;
    if (cur_col !== 7'd0 || cur_row !== 5'd0) begin
      failures++; $display("FAIL reset_cursor got=(%0d,%0d) exp=(0,0)", cur_col, cur_row);
    end
    rst = 1'b1;
    check_full_clear("init_clear");
  endtask

  task automatic test_char();
    in_char = 8'h41; in_attr = 8'h1F; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (vram_we !== 1'b1 || vram_a !== 32'd0 || vram_d !== 32'h0000_1F41) begin
      failures++; $display("FAIL char_write we=%b a=%h d=%h exp 1 0 00001f41", vram_we, vram_a, vram_d);
    end
    checks++;
    if (in_ready !== 1'b0) begin failures++; $display("FAIL char_busy ready=%b exp 0", in_ready); end
    @(negedge clk);
    checks++;
    if (cur_col !== 7'd1 || cur_row !== 5'd0 || in_ready !== 1'b1 || vram_we !== 1'b0) begin
      failures++;
      $display("FAIL char_after col=%0d row=%0d ready=%b we=%b exp 1 0 1 0", cur_col, cur_row, in_ready, vram_we);
    end
  endtask

  task automatic test_wrap();
    int bad = 0;
    send_byte(8'h0A, 8'h00);
    send_byte(8'h0A, 8'h00);
    for (int i = 0; i < 89; i++) send_byte(8'h78, 8'h00);
    wait_ready();
    checks++;
    if (cur_col !== 7'd89 || cur_row !== 5'd2) begin
      failures++; $display("FAIL wrap_setup got=(%0d,%0d) exp=(89,2)", cur_col, cur_row);
    end
    in_char = 8'h5A; in_attr = 8'h07; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (vram_we !== 1'b1 || vram_a !== 32'h0000_0434 || vram_d !== 32'h0000_075A) begin
      failures++; $display("FAIL wrap_write we=%b a=%h d=%h exp 1 00000434 0000075a", vram_we, vram_a, vram_d);
    end
    @(negedge clk);
    checks++;
    if (vram_we !== 1'b0 || cur_col !== 7'd0 || cur_row !== 5'd3) begin
      failures++; $display("FAIL wrap_cursor we=%b got=(%0d,%0d) exp we=0 (0,3)", vram_we, cur_col, cur_row);
    end
    for (int k = 0; k < 90; k++) begin
      @(negedge clk);
      if (vram_we !== 1'b1 || vram_a !== 32'((270 + k) * 4) || vram_d !== 32'h0000_0720) bad++;
    end
    checks++;
    if (bad !== 0) begin failures++; $display("FAIL wrap_row_clear bad=%0d exp=0", bad); end
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL wrap_idle ready=%b exp 1", in_ready); end
    @(negedge clk);
    checks++;
    if (vram_we !== 1'b0) begin failures++; $display("FAIL wrap_we_drop we=%b exp 0", vram_we); end
  endtask

  task automatic test_lf_wrap();
    int bad = 0;
    int hit = 0;
    for (int i = 0; i < 26; i++) send_byte(8'h0A, 8'h00);
    for (int i = 0; i < 5; i++) send_byte(8'h20, 8'h00);
    wait_ready();
    checks++;
    if (cur_col !== 7'd5 || cur_row !== 5'd29) begin
      failures++; $display("FAIL lf_setup got=(%0d,%0d) exp=(5,29)", cur_col, cur_row);
    end
    in_char = 8'h0A; in_attr = 8'h02; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (cur_col !== 7'd0 || cur_row !== 5'd0 || vram_we !== 1'b0) begin
      failures++; $display("FAIL lf_cursor got=(%0d,%0d) we=%b exp (0,0) we=0", cur_col, cur_row, vram_we);
    end
    for (int k = 0; k < 90; k++) begin
      @(negedge clk);
      if (vram_we !== 1'b1 || vram_a !== 32'(k * 4) || vram_d !== 32'h0000_0220) bad++;
      if (vram_a === 32'(2615 * 4)) hit++;
    end
    checks++;
    if (bad !== 0) begin failures++; $display("FAIL lf_row0_clear bad=%0d exp=0", bad); end
    checks++;
    if (hit !== 0) begin failures++; $display("FAIL lf_no_2615 hits=%0d exp=0", hit); end
  endtask

  task automatic test_ctrl();
    logic [7:0] codes [4];
    logic [6:0] exp_col [4];
    int wes = 0;
    codes   = '{8'h0D, 8'h08, 8'h08, 8'h07};
    exp_col = '{7'd0, 7'd0, 7'd2, 7'd2};
    wait_ready();
    for (int i = 0; i < 7; i++) send_byte(8'h0A, 8'h00);
    for (int i = 0; i < 40; i++) send_byte(8'h2E, 8'h00);
    wait_ready();
    checks++;
    if (cur_col !== 7'd40 || cur_row !== 5'd7) begin
      failures++; $display("FAIL ctrl_setup got=(%0d,%0d) exp=(40,7)", cur_col, cur_row);
    end
    for (int i = 0; i < 4; i++) begin
      if (i == 2) begin
        for (int j = 0; j < 3; j++) send_byte(8'h2E, 8'h00);
        wait_ready();
      end
      wes = 0;
      in_char = codes[i]; in_attr = 8'h33; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      if (vram_we !== 1'b0) wes++;
      checks++;
      if (cur_col !== exp_col[i] || cur_row !== 5'd7) begin
        failures++;
        $display("FAIL ctrl_%0d code=%h got=(%0d,%0d) exp=(%0d,7)", i, codes[i], cur_col, cur_row, exp_col[i]);
      end
      @(negedge clk);
      if (vram_we !== 1'b0) wes++;
      checks++;
      if (wes !== 0 || in_ready !== 1'b1) begin
        failures++; $display("FAIL ctrl_nowrite_%0d we_cycles=%0d ready=%b exp 0 1", i, wes, in_ready);
      end
    end
  endtask

  task automatic test_back_to_back();
    int writes = 0;
    logic [31:0] a2;
    a2 = 32'hFFFF_FFFF;
    in_char = 8'h42; in_attr = 8'h0E; in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (vram_we === 1'b1) begin
        writes++;
        a2 = vram_a;
      end
    end
    in_valid = 1'b0;
    checks++;
    if (writes !== 2 || cur_col !== 7'd4) begin
      failures++; $display("FAIL b2b_count writes=%0d col=%0d exp 2 4", writes, cur_col);
    end
    checks++;
    if (a2 !== 32'h0000_09E4) begin failures++; $display("FAIL b2b_addr got=%h exp=000009e4", a2); end
  endtask

  task automatic test_reset_mid_clear();
    send_byte(8'h0C, 8'h55);
    checks++;
    if (cur_col !== 7'd0 || cur_row !== 5'd0) begin
      failures++; $display("FAIL ff_cursor got=(%0d,%0d) exp=(0,0)", cur_col, cur_row);
    end
    repeat (1000) @(negedge clk);
    checks++;
    if (vram_we !== 1'b1 || vram_d !== 32'h0000_5520 || vram_a !== 32'(999 * 4)) begin
      failures++; $display("FAIL ff_midclear we=%b a=%h d=%h exp 1 00000f9c 00005520", vram_we, vram_a, vram_d);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (vram_we !== 1'b0 || in_ready !== 1'b0 || vram_a !== 32'd0) begin
      failures++; $display("FAIL rst_mid_drop we=%b ready=%b a=%h exp 0 0 0", vram_we, in_ready, vram_a);
    end
    @(negedge clk);
    rst = 1'b1;
    check_full_clear("rst_mid_clear");
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b0;
    in_char  = 8'h00;
    in_attr  = 8'h00;
    in_valid = 1'b0;
    @(negedge clk);
    test_reset();
    test_char();
    test_wrap();
    test_lf_wrap();
    test_ctrl();
    test_back_to_back();
    test_reset_mid_clear();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
